// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// The optional overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic bit width_ok(input int width);
        return (width >= 1) && (width <= 64);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder: the only arithmetic in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are added LSB-first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_adder: WIDTH must be in 1..64");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_shifted;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sum_shifted            = sum_sr >> 1;
        sum_shifted[WIDTH-1]   = fa_s;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_shifted;
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic msb_ci;

    // The carry FF still holds the carry into the MSB just before the last shift edge.
    always_ff @(posedge clk) begin
        if (rst)                                msb_ci <= 1'b0;
        else if (state == SHIFT && cnt == LAST) msb_ci <= carry;
    end

    assign ovf = msb_ci ^ carry;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_sr;
    assign cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed table, corner sequences, random adds.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for acceptance, measure latency to out_valid, return result.
    task automatic run_add(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                           output int lat, output logic [W-1:0] rs, output logic rc,
                           output logic ro);
        int guard;
        guard = 0;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        while (!in_ready && guard < 40) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        rs = sum;
        rc = cout;
`ifdef SERIAL_ADDER_OVF_EN
        ro = ovf;
`else
        ro = 1'b0;
`endif
    endtask

    // Complete the output handshake and leave out_ready as it was.
    task automatic drain();
        logic keep;
        keep = out_ready;
        out_ready = 1'b1;
        tick();
        out_ready = keep;
    endtask

    initial begin
        int           lat;
        logic [W-1:0] rs;
        logic         rc;
        logic         ro;
        logic [W-1:0] hold_sum;
        logic         hold_cout;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h05, 8'hFB, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset sum", sum, 0);
        check("reset cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset ovf", ovf, 0);
`endif

        for (int i = 0; i < 8; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, lat, rs, rc, ro);
            check($sformatf("vec%0d latency", i), lat, W);
            check($sformatf("vec%0d sum", i), rs, vecs[i].sum);
            check($sformatf("vec%0d cout", i), rc, vecs[i].cout);
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("vec%0d ovf", i), ro, vecs[i].ovf);
`endif
            drain();
        end

        // Backpressure: result must hold and new operands must be refused.
        run_add(8'hA0, 8'h0B, 1'b1, lat, rs, rc, ro);
        check("bp latency", lat, W);
        check("bp first sum", rs, 8'hAC);
        hold_sum = sum;
        hold_cout = cout;
        a = 8'h33; b = 8'h44; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp sum stable", sum, hold_sum);
            check("bp cout stable", cout, hold_cout);
            check("bp in_ready low", in_ready, 0);
            check("bp out_valid held", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp in_ready back", in_ready, 1);
        check("bp out_valid cleared", out_valid, 0);
        run_add(8'h33, 8'h44, 1'b0, lat, rs, rc, ro);
        check("bp second latency", lat, W);
        check("bp second sum", rs, 8'h77);
        check("bp second cout", rc, 0);
        drain();

        // Reset during shift cycle 3 aborts the add.
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("abort busy", busy, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort in_ready", in_ready, 1);
        check("abort out_valid", out_valid, 0);
        check("abort busy idle", busy, 0);
        tick();
        check("abort no result", out_valid, 0);
        run_add(8'h12, 8'h34, 1'b0, lat, rs, rc, ro);
        check("post-abort latency", lat, W);
        check("post-abort sum", rs, 8'h46);
        check("post-abort cout", rc, 0);
        drain();

        // Random back-to-back adds against an arithmetic model.
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rcin;
            logic [W:0]   exp;
            int           s_signed;
            ra = W'($urandom);
            rb = W'($urandom);
            rcin = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
            s_signed = int'($signed(ra)) + int'($signed(rb)) + int'(rcin);
            run_add(ra, rb, rcin, lat, rs, rc, ro);
            check("rand latency", lat, W);
            check("rand sum", rs, exp[W-1:0]);
            check("rand cout", rc, exp[W]);
`ifdef SERIAL_ADDER_OVF_EN
            check("rand ovf", ro, (s_signed > 127 || s_signed < -128) ? 1 : 0);
`endif
            drain();
        end
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
